fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake on one side, decode hand-off on the other.
// The master modport is the fetch stage; the slave modport is the memory/decode environment.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stallD;
  logic        flushD;
  logic [31:0] redirect_pc;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcF;
  logic [31:0] pcplusfourF;

  modport master (
    output imem_req, imem_addr, validD, instrD, pcF, pcplusfourF,
    input  imem_gnt, imem_rvalid, imem_rdata, stallD, flushD, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, validD, instrD, pcF, pcplusfourF,
    output imem_gnt, imem_rvalid, imem_rdata, stallD, flushD, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, issues word requests over req/gnt/rvalid,
// buffers responses in an in-order queue and hands them to decode, squashing on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master bus
);
  localparam int          AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]          pc_q   [BUF_DEPTH];
  logic [31:0]          data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [AW-1:0]        fptr_q, fptr_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic [CW-1:0]        unf_q, unf_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [31:0]          fpc_q, fpc_d;

  logic [CW:0] used;
  logic        req, fire, fill_evt, drop_evt, rsp_used, valid, pop;
  logic [31:0] head_pc;

  // Credit covers both live queue entries and stale responses still owed by memory.
  assign used     = {1'b0, occ_q} + {1'b0, drop_q};
  assign req      = rstn & ~bus.flushD & (used < DEPTH_C);
  assign fire     = req & bus.imem_gnt;
  assign rsp_used = bus.imem_rvalid & ((drop_q != '0) | (unf_q != '0));
  assign drop_evt = bus.imem_rvalid & (drop_q != '0);
  assign fill_evt = bus.imem_rvalid & (drop_q == '0) & (unf_q != '0);
  assign valid    = (occ_q != '0) & filled_q[head_q] & ~bus.flushD;
  assign pop      = valid & ~bus.stallD;

  always_comb begin
    fpc_d    = fpc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fptr_d   = fptr_q;
    filled_d = filled_q;
    occ_d    = occ_q;
    unf_d    = unf_q;
    drop_d   = drop_q;
    if (bus.flushD) begin
      // Every unfilled entry becomes a response to discard; this cycle's rvalid retires one of them.
      fpc_d    = bus.redirect_pc & ~32'h3;
      head_d   = '0;
      tail_d   = '0;
      fptr_d   = '0;
      filled_d = '0;
      occ_d    = '0;
      unf_d    = '0;
      drop_d   = drop_q + unf_q - CW'(rsp_used);
    end else begin
      if (fire) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + AW'(1);
        fpc_d            = fpc_q + 32'd4;
      end
      if (fill_evt) begin
        filled_d[fptr_q] = 1'b1;
        fptr_d           = fptr_q + AW'(1);
      end
      if (drop_evt) drop_d = drop_q - CW'(1);
      if (pop)      head_d = head_q + AW'(1);
      occ_d = occ_q + CW'(fire) - CW'(pop);
      unf_d = unf_q + CW'(fire) - CW'(fill_evt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpc_q    <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      filled_q <= '0;
      occ_q    <= '0;
      unf_q    <= '0;
      drop_q   <= '0;
    end else begin
      fpc_q    <= fpc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fptr_q   <= fptr_d;
      filled_q <= filled_d;
      occ_q    <= occ_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage needs no reset: an entry is only read once allocated and filled.
  always_ff @(posedge clk) begin
    if (fire)     pc_q[tail_q]   <= fpc_q;
    if (fill_evt) data_q[fptr_q] <= bus.imem_rdata;
  end

  assign head_pc         = (occ_q != '0) ? pc_q[head_q] : fpc_q;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc_q;
  assign bus.validD      = valid;
  assign bus.instrD      = valid ? data_q[head_q] : NOP;
  assign bus.pcF         = head_pc;
  assign bus.pcplusfourF = head_pc + 32'd4;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a memory model answers requests in order, and the
// expected decode stream is a plain PC sequence that restarts at every redirect or reset.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_fpc = RESET_PC;
  int n_chk = 0, n_pass = 0, n_fail = 0, n_deliv = 0, cyc = 0;
  int lat_min = 1, lat_max = 1, gnt_pct = 100, stall_pct = 0, flush_pct = 0;
  bit rst_prev = 1'b1, arm_first = 1'b0, first_pending = 1'b0;
  int rel_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(1) == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom & 32'h0000_0FFF;
  endfunction

  // One clock of stimulus: memory model, handshake inputs, credit/address checks, model update.
  task automatic step(input bit st, input bit fl, input logic [31:0] rpc, input bit rn);
    bit resp, fire;
    int stale;
    @(negedge clk);
    cyc++;
    rstn = rn;
    resp = 1'b0;
    if (rn && pend.size() > 0) resp = (pend[0].rdy <= cyc);
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? mem_word(pend[0].addr) : $urandom;
    bus.imem_gnt    = rn && ($urandom_range(99) < gnt_pct);
    bus.stallD      = st;
    bus.flushD      = fl;
    bus.redirect_pc = rpc;
    if (rn && !rst_prev && arm_first) begin
      rel_cyc = cyc;
      first_pending = 1'b1;
      arm_first = 1'b0;
    end
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].stale) stale++;
    check("imem_req", 32'(bus.imem_req), 32'(rn && !fl && (exp_q.size() + stale < DEPTH)));
    if (!rn) begin
      if (!rst_prev) begin
        check("rst_validD", 32'(bus.validD), 32'd0);
        check("rst_instrD", bus.instrD, NOP);
        check("rst_pcF", bus.pcF, RESET_PC);
        check("rst_pcplusfourF", bus.pcplusfourF, RESET_PC + 32'd4);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
      end
      pend.delete();
      exp_q.delete();
      model_fpc = RESET_PC;
    end else begin
      if (resp) pend.delete(0);
      fire = bus.imem_req && bus.imem_gnt;
      if (fire) begin
        check("imem_addr", bus.imem_addr, model_fpc);
        pend.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
        exp_q.push_back(model_fpc);
        model_fpc += 32'd4;
      end
      if (fl) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        model_fpc = rpc & ~32'h3;
      end
    end
    rst_prev = rn;
  endtask

  task automatic rand_step();
    step($urandom_range(99) < stall_pct, $urandom_range(99) < flush_pct, rand_pc(), 1'b1);
  endtask

  // Monitor: compares every instruction decode accepts against the head of the expected stream.
  initial begin
    bit          prev_hold;
    logic [31:0] prev_pc, prev_instr, e;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        if (prev_hold && !bus.flushD) begin
          check("stall_validD", 32'(bus.validD), 32'd1);
          check("stall_pcF", bus.pcF, prev_pc);
          check("stall_instrD", bus.instrD, prev_instr);
        end
        if (bus.flushD) check("flush_validD", 32'(bus.validD), 32'd0);
        if (bus.validD) begin
          if (first_pending) begin
            check("first_valid_latency", 32'(cyc - rel_cyc), 32'd2);
            first_pending = 1'b0;
          end
          if (!bus.stallD) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL spurious_validD: got pcF=%h instrD=%h, required no instruction (cycle %0d)",
                       bus.pcF, bus.instrD, cyc);
            end else begin
              e = exp_q.pop_front();
              check("pcF", bus.pcF, e);
              check("instrD", bus.instrD, mem_word(e));
              check("pcplusfourF", bus.pcplusfourF, e + 32'd4);
              n_deliv++;
            end
          end
        end else begin
          check("instrD_nop", bus.instrD, NOP);
        end
        prev_hold  = bus.validD && bus.stallD;
        prev_pc    = bus.pcF;
        prev_instr = bus.instrD;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.stallD      = 1'b0;
    bus.flushD      = 1'b0;
    bus.redirect_pc = '0;
    arm_first = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    repeat (30) step(1'b0, 1'b0, '0, 1'b1);
    if (first_pending) begin
      n_chk++;
      n_fail++;
      $display("FAIL first_valid_latency: got no validD, required validD at cycle %0d", rel_cyc + 2);
      first_pending = 1'b0;
    end

    // Decode stall holding the head while fetch fills the remaining credit.
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    // Redirects with responses still in flight, unaligned target, and PC wrap.
    lat_min = 4; lat_max = 4;
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (15) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
    repeat (12) step(1'b0, 1'b0, '0, 1'b1);
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (12) step(1'b0, 1'b0, '0, 1'b1);

    for (int ph = 0; ph < 4; ph++) begin
      lat_min   = 1 + (ph / 2) * 3;
      lat_max   = lat_min + ph * 2;
      gnt_pct   = 100 - ph * 15;
      stall_pct = ph * 12;
      flush_pct = ph * 3;
      repeat (400) rand_step();
    end

    // Reset while the queue is full and decode is stalled, then restart.
    lat_min = 1; lat_max = 1; gnt_pct = 100; stall_pct = 0; flush_pct = 0;
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    repeat (20) step(1'b0, 1'b0, '0, 1'b1);

    check("deliveries_progress", 32'(n_deliv > 200), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
